// File: rtl/sgm_stream_comparator.sv
// Aligns NUM_CH disparity streams through per-channel FIFOs and compares each
// channel against channel 0 pixel by pixel, reporting frame and fault status.
module sgm_stream_comparator #(
    parameter int NUM_CH       = 3,
    parameter int DISP_W       = 6,
    parameter int FRAME_WIDTH  = 272,
    parameter int FRAME_HEIGHT = 240,
    parameter int FIFO_DEPTH   = 64,
    parameter int TOL          = 0,
    parameter int TIMEOUT      = 1048576,
    localparam int TOTAL       = FRAME_WIDTH * FRAME_HEIGHT,
    localparam int CNT_W       = $clog2(TOTAL + 1),
    localparam int X_W         = (FRAME_WIDTH > 1) ? $clog2(FRAME_WIDTH) : 1,
    localparam int Y_W         = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [NUM_CH*DISP_W-1:0]      disp_in,
    input  logic [NUM_CH-1:0]             valid_in,
    output logic                          busy,
    output logic                          done,
    output logic                          fail,
    output logic [NUM_CH-1:0]             overflow,
    output logic [NUM_CH-1:0]             excess,
    output logic                          timeout,
    output logic [(NUM_CH-1)*CNT_W-1:0]   mismatch_cnt,
    output logic [CNT_W-1:0]              cmp_count,
    output logic                          cmp_valid,
    output logic [X_W-1:0]                cmp_x,
    output logic [Y_W-1:0]                cmp_y,
    output logic [NUM_CH-2:0]             cmp_mask
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  TOTAL_C   = CNT_W'(TOTAL);
    localparam logic [PTR_W:0]    DEPTH_C   = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);
    localparam logic [X_W-1:0]    X_LAST    = X_W'(FRAME_WIDTH - 1);
    localparam logic [DISP_W:0]   TOL_C     = (DISP_W + 1)'(TOL);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_FAIL} state_t;
    state_t state;

    logic [DISP_W-1:0] mem [NUM_CH][FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr [NUM_CH];
    logic [PTR_W-1:0]  rd_ptr [NUM_CH];
    logic [PTR_W:0]    fill [NUM_CH];
    logic [CNT_W-1:0]  in_count [NUM_CH];
    logic [CNT_W-1:0]  mm_cnt [NUM_CH-1];
    logic [IDLE_W-1:0] idle_cnt;
    logic [X_W-1:0]    x;
    logic [Y_W-1:0]    y;

    logic              pop;
    logic              active;
    logic              timeout_hit;
    logic [NUM_CH-1:0] push, ovf_now, exc_now, full;
    logic [NUM_CH-2:0] mask_now;
    logic [DISP_W:0]   base, chan, diff;

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);
    assign fail = (state == S_FAIL);

    for (genvar g = 0; g < NUM_CH - 1; g++) begin : g_mm
        assign mismatch_cnt[g*CNT_W +: CNT_W] = mm_cnt[g];
    end

    // A full FIFO may still accept a word when it is popped in the same cycle.
    always_comb begin
        pop     = (state == S_RUN);
        push    = '0;
        ovf_now = '0;
        exc_now = '0;
        full    = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            full[k] = (fill[k] == DEPTH_C);
            pop     = pop && (fill[k] != '0);
        end
        for (int k = 0; k < NUM_CH; k++) begin
            if (state == S_RUN && valid_in[k]) begin
                exc_now[k] = (in_count[k] == TOTAL_C);
                ovf_now[k] = !exc_now[k] && full[k] && !pop;
                push[k]    = !exc_now[k] && !ovf_now[k];
            end
        end
        active      = pop || (|valid_in);
        timeout_hit = (state == S_RUN) && !active && (idle_cnt == IDLE_LAST);
    end

    always_comb begin
        mask_now = '0;
        chan     = '0;
        diff     = '0;
        base     = {1'b0, mem[0][rd_ptr[0]]};
        for (int k = 1; k < NUM_CH; k++) begin
            chan          = {1'b0, mem[k][rd_ptr[k]]};
            diff          = (chan >= base) ? (chan - base) : (base - chan);
            mask_now[k-1] = (diff > TOL_C);
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_CH; k++) begin
            if (push[k]) mem[k][wr_ptr[k]] <= disp_in[k*DISP_W +: DISP_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || (start && state != S_RUN)) begin
            state <= rst ? S_IDLE : S_RUN;
            for (int k = 0; k < NUM_CH; k++) begin
                wr_ptr[k]   <= '0;
                rd_ptr[k]   <= '0;
                fill[k]     <= '0;
                in_count[k] <= '0;
            end
            for (int k = 0; k < NUM_CH - 1; k++) mm_cnt[k] <= '0;
            overflow  <= '0;
            excess    <= '0;
            timeout   <= 1'b0;
            cmp_count <= '0;
            cmp_valid <= 1'b0;
            cmp_x     <= '0;
            cmp_y     <= '0;
            cmp_mask  <= '0;
            x         <= '0;
            y         <= '0;
            idle_cnt  <= '0;
        end else if (state == S_RUN) begin
            cmp_valid <= pop;
            for (int k = 0; k < NUM_CH; k++) begin
                if (push[k]) begin
                    wr_ptr[k]   <= wr_ptr[k] + PTR_W'(1);
                    in_count[k] <= in_count[k] + CNT_W'(1);
                end
                if (pop) rd_ptr[k] <= rd_ptr[k] + PTR_W'(1);
                if (push[k] && !pop)      fill[k] <= fill[k] + (PTR_W + 1)'(1);
                else if (!push[k] && pop) fill[k] <= fill[k] - (PTR_W + 1)'(1);
                if (ovf_now[k]) overflow[k] <= 1'b1;
                if (exc_now[k]) excess[k]   <= 1'b1;
            end
            if (pop) begin
                cmp_x     <= x;
                cmp_y     <= y;
                cmp_mask  <= mask_now;
                cmp_count <= cmp_count + CNT_W'(1);
                for (int k = 0; k < NUM_CH - 1; k++) begin
                    if (mask_now[k] && mm_cnt[k] != '1) mm_cnt[k] <= mm_cnt[k] + CNT_W'(1);
                end
                if (x == X_LAST) begin
                    x <= '0;
                    y <= y + Y_W'(1);
                end else begin
                    x <= x + X_W'(1);
                end
            end
            idle_cnt <= active ? '0 : idle_cnt + IDLE_W'(1);
            if (timeout_hit) timeout <= 1'b1;
            // DONE one cycle after the last compare strobe; faults take priority.
            if (cmp_count == TOTAL_C)       state <= S_DONE;
            if (|ovf_now || timeout_hit)    state <= S_FAIL;
        end else begin
            cmp_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_sgm_stream_comparator.sv
// Randomized bench for sgm_stream_comparator: two DUTs (TOL=0 and TOL=1) share
// the stimulus and are checked every cycle against a queue-based frame model.
module tb_sgm_stream_comparator;
    localparam int NCH = 3, DW = 6, W = 4, H = 2, TOTAL = 8, DEPTH = 4, TMO = 16;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [NCH*DW-1:0] disp_in = '0;
    logic [NCH-1:0]    valid_in = '0;

    logic busy0, done0, fail0, to0, cv0, busy1, done1, fail1, to1, cv1;
    logic [2:0] ov0, ex0, ov1, ex1;
    logic [7:0] mm0, mm1;
    logic [3:0] cc0, cc1;
    logic [1:0] x0, x1, mk0, mk1;
    logic [0:0] y0, y1;

    int checks = 0, failures = 0;
    bit chk_en = 0;

    always #5 clk = ~clk;

    sgm_stream_comparator #(.NUM_CH(NCH), .DISP_W(DW), .FRAME_WIDTH(W), .FRAME_HEIGHT(H),
        .FIFO_DEPTH(DEPTH), .TOL(0), .TIMEOUT(TMO)) u_dut0 (
        .clk(clk), .rst(rst), .start(start), .disp_in(disp_in), .valid_in(valid_in),
        .busy(busy0), .done(done0), .fail(fail0), .overflow(ov0), .excess(ex0),
        .timeout(to0), .mismatch_cnt(mm0), .cmp_count(cc0), .cmp_valid(cv0),
        .cmp_x(x0), .cmp_y(y0), .cmp_mask(mk0));

    sgm_stream_comparator #(.NUM_CH(NCH), .DISP_W(DW), .FRAME_WIDTH(W), .FRAME_HEIGHT(H),
        .FIFO_DEPTH(DEPTH), .TOL(1), .TIMEOUT(TMO)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .disp_in(disp_in), .valid_in(valid_in),
        .busy(busy1), .done(done1), .fail(fail1), .overflow(ov1), .excess(ex1),
        .timeout(to1), .mismatch_cnt(mm1), .cmp_count(cc1), .cmp_valid(cv1),
        .cmp_x(x1), .cmp_y(y1), .cmp_mask(mk1));

    // ---------------- behavioural model ----------------
    int m_state = 0;                 // 0 idle, 1 run, 2 done, 3 fail
    int q [NCH][$];
    int m_inc [NCH];
    int m_cnt, m_idle;
    int m_mm [2][2];
    logic [2:0] m_ovf, m_exc;
    logic m_to, m_cv;
    logic [6:0] exp_q [$];           // {x[1:0], y, mask tol0[1:0], mask tol1[1:0]}

    task automatic model_clear();
        for (int k = 0; k < NCH; k++) begin
            q[k].delete();
            m_inc[k] = 0;
        end
        for (int t = 0; t < 2; t++) begin
            m_mm[t][0] = 0;
            m_mm[t][1] = 0;
        end
        m_cnt = 0; m_idle = 0; m_ovf = '0; m_exc = '0; m_to = 0; m_cv = 0;
        exp_q.delete();
    endtask

    always @(posedge clk) begin
        if (rst) begin
            model_clear();
            m_state = 0;
        end else if (m_state != 1) begin
            m_cv = 0;
            if (start) begin
                model_clear();
                m_state = 1;
            end
        end else begin
            automatic bit pop = (q[0].size() > 0) && (q[1].size() > 0) && (q[2].size() > 0);
            automatic int ns = (m_cnt == TOTAL) ? 2 : 1;
            m_cv = pop;
            if (pop) begin
                automatic int b = q[0].pop_front();
                automatic logic [1:0] mk [2];
                mk[0] = '0; mk[1] = '0;
                for (int k = 1; k < NCH; k++) begin
                    automatic int v = q[k].pop_front();
                    automatic int d = (v > b) ? v - b : b - v;
                    for (int t = 0; t < 2; t++) begin
                        if (d > t) begin
                            mk[t][k-1] = 1'b1;
                            m_mm[t][k-1]++;
                        end
                    end
                end
                exp_q.push_back({2'(m_cnt % W), 1'(m_cnt / W), mk[0], mk[1]});
                m_cnt++;
            end
            for (int k = 0; k < NCH; k++) begin
                if (valid_in[k]) begin
                    if (m_inc[k] == TOTAL) m_exc[k] = 1'b1;
                    else if (q[k].size() >= DEPTH) begin
                        m_ovf[k] = 1'b1;
                        ns = 3;
                    end else begin
                        q[k].push_back(int'(disp_in[k*DW +: DW]));
                        m_inc[k]++;
                    end
                end
            end
            if (pop || (|valid_in)) m_idle = 0;
            else begin
                m_idle++;
                if (m_idle == TMO) begin
                    m_to = 1'b1;
                    ns = 3;
                end
            end
            m_state = ns;
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_dut(input string tag, input int i, input logic b, d, f, t, cv,
                             input logic [2:0] ov, ex, input logic [3:0] cc, input logic [7:0] mm);
        check({tag, "_busy"}, b, int'(m_state == 1));
        check({tag, "_done"}, d, int'(m_state == 2));
        check({tag, "_fail"}, f, int'(m_state == 3));
        check({tag, "_timeout"}, t, m_to);
        check({tag, "_cmp_valid"}, cv, m_cv);
        check({tag, "_overflow"}, ov, m_ovf);
        check({tag, "_excess"}, ex, m_exc);
        check({tag, "_cmp_count"}, cc, m_cnt);
        check({tag, "_mismatch_cnt"}, mm, m_mm[i][1] * 16 + m_mm[i][0]);
    endtask

    int cyc = 0, first_v = -1, first_c = -1, last_c = -1, fail_c = -1, n_cmp = 0;
    logic [1:0] seen_mask = '0, seen_x = '0;
    logic seen_y = 1'b0;

    always @(posedge clk) begin
        if (valid_in[1] && first_v < 0) first_v = cyc;
        cyc = cyc + 1;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check_dut("d0", 0, busy0, done0, fail0, to0, cv0, ov0, ex0, cc0, mm0);
            check_dut("d1", 1, busy1, done1, fail1, to1, cv1, ov1, ex1, cc1, mm1);
            if (cv0) begin
                n_cmp++;
                last_c = cyc;
                if (first_c < 0) first_c = cyc;
                if (mk0 != 2'b00) begin
                    seen_mask = mk0; seen_x = x0; seen_y = y0[0];
                end
                if (exp_q.size() == 0) check("cmp_unexpected", 1, 0);
                else begin
                    automatic logic [6:0] e = exp_q.pop_front();
                    check("cmp_x", x0, e[6:5]);
                    check("cmp_y", y0, e[4]);
                    check("cmp_mask_tol0", mk0, e[3:2]);
                    check("cmp_mask_tol1", mk1, e[1:0]);
                end
            end
            if (fail0 && fail_c < 0) fail_c = cyc;
        end
    end

    // ---------------- drivers ----------------
    logic [DW-1:0] frame [TOTAL];
    logic [DW-1:0] bump_amt = 6'd1;

    task automatic new_frame(input bit ramp);
        for (int i = 0; i < TOTAL; i++) frame[i] = ramp ? DW'(i) : DW'($urandom_range(0, 60));
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic clear_mon();
        first_v = -1; first_c = -1; last_c = -1; fail_c = -1; n_cmp = 0; seen_mask = '0;
    endtask

    // Channel k sends n[k] samples starting d[k] cycles in; bump_ch gets +bump_amt at bump_px.
    task automatic stream(input int d0, d1, d2, n0, n1, n2, bump_ch, bump_px);
        int d [NCH];
        int n [NCH];
        int span;
        d[0] = d0; d[1] = d1; d[2] = d2;
        n[0] = n0; n[1] = n1; n[2] = n2;
        span = 0;
        for (int k = 0; k < NCH; k++) if (d[k] + n[k] > span) span = d[k] + n[k];
        for (int t = 0; t < span; t++) begin
            for (int k = 0; k < NCH; k++) begin
                automatic int p = t - d[k];
                if (p >= 0 && p < n[k]) begin
                    valid_in[k] = 1'b1;
                    disp_in[k*DW +: DW] = frame[p % TOTAL] +
                        ((k == bump_ch && p == bump_px) ? bump_amt : DW'(0));
                end else begin
                    valid_in[k] = 1'b0;
                    disp_in[k*DW +: DW] = DW'($urandom_range(0, 63));
                end
            end
            @(negedge clk);
        end
        valid_in = '0;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        repeat (2) @(negedge clk);
        chk_en = 1;
        rst = 1'b0;
        check("rst_busy", busy0, 0);
        check("rst_done", done0, 0);
        check("rst_fail", fail0, 0);
        check("rst_cmp_count", cc0, 0);
        check("rst_mismatch", mm0, 0);

        // identical streams
        new_frame(1);
        pulse_start(); clear_mon();
        stream(0, 0, 0, 8, 8, 8, 3, 0);
        idle(4);
        check("ident_done", done0, 1);
        check("ident_count", cc0, 8);
        check("ident_pulses", n_cmp, 8);
        check("ident_mismatch", mm0, 0);

        // skewed latency
        pulse_start(); clear_mon();
        stream(0, 3, 1, 8, 8, 8, 3, 0);
        idle(4);
        check("skew_done", done0, 1);
        check("skew_pulses", n_cmp, 8);
        check("skew_latency", first_c - first_v, 2);
        check("skew_mismatch", mm0, 0);

        // single mismatch on ch2 pixel 5
        new_frame(0);
        pulse_start(); clear_mon();
        stream(0, 0, 0, 8, 8, 8, 2, 5);
        idle(4);
        check("mm_tol0_cnt", mm0, 8'h10);
        check("mm_tol1_cnt", mm1, 0);
        check("mm_mask", seen_mask, 2'b10);
        check("mm_x", seen_x, 1);
        check("mm_y", seen_y, 1);
        check("mm_done_tol1", done1, 1);

        // overflow on ch0
        pulse_start(); clear_mon();
        stream(0, 0, 0, 5, 0, 0, 3, 0);
        check("ovf_fail_now", fail0, 1);
        idle(2);
        check("ovf_flags", ov0, 3'b001);
        check("ovf_done", done0, 0);

        // timeout after 6 samples
        pulse_start(); clear_mon();
        stream(0, 0, 0, 6, 6, 6, 3, 0);
        idle(24);
        check("to_flag", to0, 1);
        check("to_fail", fail0, 1);
        check("to_count", cc0, 6);
        check("to_delay", fail_c - last_c, 16);

        // excess during RUN
        pulse_start(); clear_mon();
        stream(0, 0, 0, 9, 8, 8, 3, 0);
        idle(4);
        check("exc_run_flag", ex0, 3'b001);
        check("exc_run_done", done0, 1);

        // extra sample after DONE is ignored
        pulse_start(); clear_mon();
        stream(0, 0, 0, 8, 8, 8, 3, 0);
        idle(4);
        valid_in = 3'b001;
        @(negedge clk);
        valid_in = '0;
        idle(2);
        check("exc_done_flag", ex0, 0);
        check("exc_done_count", cc0, 8);

        // reset mid-frame, then a clean pass
        pulse_start(); clear_mon();
        stream(0, 0, 0, 5, 5, 5, 3, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_busy", busy0, 0);
        check("mid_rst_count", cc0, 0);
        check("mid_rst_valid", cv0, 0);
        pulse_start(); clear_mon();
        stream(0, 0, 0, 8, 8, 8, 3, 0);
        idle(4);
        check("post_rst_done", done0, 1);
        check("post_rst_pulses", n_cmp, 8);

        // randomized frames: skew, lengths and bumps chosen at random
        for (int it = 0; it < 16; it++) begin
            new_frame(0);
            bump_amt = DW'($urandom_range(1, 2));
            pulse_start(); clear_mon();
            stream($urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5),
                   $urandom_range(6, 9), $urandom_range(7, 9), $urandom_range(7, 9),
                   $urandom_range(0, 3), $urandom_range(0, 7));
            idle(24);
        end

        check("exp_q_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
